// File: rtl/mem32_arbiter.sv
// Round-robin arbiter sharing the 32-bit mem32 request port between NUM_REQ clients.
// Optional build macro MEM32_ARB_PRIO0_EN gives client 0 fixed top priority.
module mem32_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 26
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_request,
  input  logic [NUM_REQ*ADDR_W-1:0] req_address,
  input  logic [NUM_REQ-1:0]        req_direction,
  input  logic [NUM_REQ*4-1:0]      req_byte_en,
  input  logic [NUM_REQ*32-1:0]     req_wdata,
  input  logic [NUM_REQ*5-1:0]      req_tag,
  output logic [NUM_REQ-1:0]        req_dack,
  output logic [NUM_REQ-1:0]        req_rack,
  output logic [4:0]                req_rack_tag,
  output logic [31:0]               req_rdata,
  output logic                      mem32_request,
  output logic [ADDR_W-1:0]         mem32_address,
  output logic                      mem32_direction,
  output logic [3:0]                mem32_byte_en,
  output logic [31:0]               mem32_wdata,
  output logic [7:0]                mem32_tag,
  input  logic [7:0]                mem32_dack_tag,
  input  logic [31:0]               mem32_rdata,
  input  logic                      mem32_rack,
  input  logic [7:0]                mem32_rack_tag
);

  typedef enum logic {IDLE, ISSUE} state_t;

  localparam logic [1:0] LAST_ID = 2'(NUM_REQ - 1);

  state_t              state_q, state_d;
  logic [1:0]          rrPtr_q, rrPtr_d;
  logic [1:0]          grant_q, grant_d;
  logic                request_q, request_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                dir_q, dir_d;
  logic [3:0]          be_q, be_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [7:0]          tag_q, tag_d;

  logic [NUM_REQ-1:0]  eligible;
  logic [1:0]          cand;
  logic [1:0]          pick;
  logic                found;
  logic                tagHit;

  // Pick the first eligible client at or after rrPtr_q, wrapping at NUM_REQ.
  always_comb begin
    eligible = req_request;
    found    = 1'b0;
    pick     = '0;
    cand     = '0;
`ifdef MEM32_ARB_PRIO0_EN
    if (req_request[0]) begin
      found = 1'b1;
    end
    eligible[0] = 1'b0;
`endif
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = 2'((int'(rrPtr_q) + k) % NUM_REQ);
      if (!found && eligible[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  assign tagHit = (mem32_dack_tag == tag_q);

  always_comb begin
    state_d   = state_q;
    rrPtr_d   = rrPtr_q;
    grant_d   = grant_q;
    request_d = request_q;
    addr_d    = addr_q;
    dir_d     = dir_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    tag_d     = tag_q;
    req_dack  = '0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          addr_d    = req_address[pick*ADDR_W +: ADDR_W];
          dir_d     = req_direction[pick];
          be_d      = req_byte_en[pick*4 +: 4];
          wdata_d   = req_wdata[pick*32 +: 32];
          tag_d     = {1'b1, pick, req_tag[pick*5 +: 5]};
          request_d = 1'b1;
          grant_d   = pick;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        if (tagHit) begin
          // Accept is suppressed while reset is asserted: the request is being dropped.
          req_dack[grant_q] = reset_n;
          request_d         = 1'b0;
          state_d           = IDLE;
          rrPtr_d           = (grant_q == LAST_ID) ? 2'd0 : grant_q + 2'd1;
`ifdef MEM32_ARB_PRIO0_EN
          if (grant_q == 2'd0) begin
            rrPtr_d = rrPtr_q;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      rrPtr_q   <= '0;
      grant_q   <= '0;
      request_q <= 1'b0;
      addr_q    <= '0;
      dir_q     <= 1'b0;
      be_q      <= '0;
      wdata_q   <= '0;
      tag_q     <= '0;
    end else begin
      state_q   <= state_d;
      rrPtr_q   <= rrPtr_d;
      grant_q   <= grant_d;
      request_q <= request_d;
      addr_q    <= addr_d;
      dir_q     <= dir_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      tag_q     <= tag_d;
    end
  end

  assign mem32_request   = request_q;
  assign mem32_address   = addr_q;
  assign mem32_direction = dir_q;
  assign mem32_byte_en   = be_q;
  assign mem32_wdata     = wdata_q;
  assign mem32_tag       = tag_q;

  // Read returns are routed purely from the returning tag; IDs past NUM_REQ match nothing.
  always_comb begin
    req_rack = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      req_rack[j] = mem32_rack & mem32_rack_tag[7] & (mem32_rack_tag[6:5] == 2'(j));
    end
  end

  assign req_rdata    = mem32_rdata;
  assign req_rack_tag = mem32_rack_tag[4:0];

endmodule

// File: tb/tb_mem32_arbiter.sv
// Directed bench for mem32_arbiter: a transaction-level model checked every cycle,
// plus literal expectations for tags, grant order, routing and reset behaviour.
module tb_mem32_arbiter;

  localparam int NR = 4;
  localparam int AW = 26;
`ifdef MEM32_ARB_PRIO0_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic [NR-1:0]     req_request = '0;
  logic [NR*AW-1:0]  req_address = '0;
  logic [NR-1:0]     req_direction = '0;
  logic [NR*4-1:0]   req_byte_en = '0;
  logic [NR*32-1:0]  req_wdata = '0;
  logic [NR*5-1:0]   req_tag = '0;
  logic [NR-1:0]     req_dack;
  logic [NR-1:0]     req_rack;
  logic [4:0]        req_rack_tag;
  logic [31:0]       req_rdata;
  logic              mem32_request;
  logic [AW-1:0]     mem32_address;
  logic              mem32_direction;
  logic [3:0]        mem32_byte_en;
  logic [31:0]       mem32_wdata;
  logic [7:0]        mem32_tag;
  logic [7:0]        mem32_dack_tag = '0;
  logic [31:0]       mem32_rdata = '0;
  logic              mem32_rack = 1'b0;
  logic [7:0]        mem32_rack_tag = '0;

  // Three-client instance, used only to check routing of out-of-range IDs.
  logic [2:0]        n3Zero1 = '0;
  logic [3*AW-1:0]   n3ZeroAddr = '0;
  logic [3*4-1:0]    n3ZeroBe = '0;
  logic [3*32-1:0]   n3ZeroData = '0;
  logic [3*5-1:0]    n3ZeroTag = '0;
  logic [2:0]        n3Dack, n3Rack;
  logic [4:0]        n3RackTag;
  logic [31:0]       n3Rdata, n3Wdata;
  logic              n3Request, n3Dir;
  logic [AW-1:0]     n3Addr;
  logic [3:0]        n3Be;
  logic [7:0]        n3Tag;

  always #5 clock = ~clock;

  mem32_arbiter #(.NUM_REQ(NR), .ADDR_W(AW)) u_dut (
    .clock(clock), .reset_n(reset_n),
    .req_request(req_request), .req_address(req_address), .req_direction(req_direction),
    .req_byte_en(req_byte_en), .req_wdata(req_wdata), .req_tag(req_tag),
    .req_dack(req_dack), .req_rack(req_rack), .req_rack_tag(req_rack_tag), .req_rdata(req_rdata),
    .mem32_request(mem32_request), .mem32_address(mem32_address),
    .mem32_direction(mem32_direction), .mem32_byte_en(mem32_byte_en),
    .mem32_wdata(mem32_wdata), .mem32_tag(mem32_tag), .mem32_dack_tag(mem32_dack_tag),
    .mem32_rdata(mem32_rdata), .mem32_rack(mem32_rack), .mem32_rack_tag(mem32_rack_tag)
  );

  mem32_arbiter #(.NUM_REQ(3), .ADDR_W(AW)) u_dut3 (
    .clock(clock), .reset_n(reset_n),
    .req_request(n3Zero1), .req_address(n3ZeroAddr), .req_direction(n3Zero1),
    .req_byte_en(n3ZeroBe), .req_wdata(n3ZeroData), .req_tag(n3ZeroTag),
    .req_dack(n3Dack), .req_rack(n3Rack), .req_rack_tag(n3RackTag), .req_rdata(n3Rdata),
    .mem32_request(n3Request), .mem32_address(n3Addr),
    .mem32_direction(n3Dir), .mem32_byte_en(n3Be),
    .mem32_wdata(n3Wdata), .mem32_tag(n3Tag), .mem32_dack_tag(mem32_dack_tag),
    .mem32_rdata(mem32_rdata), .mem32_rack(mem32_rack), .mem32_rack_tag(mem32_rack_tag)
  );

  int nCompared = 0;
  int nFail = 0;
  bit checkEn = 1'b0;
  int dackLog[$];
  int dackCnt[NR];
  int rackCnt = 0;

  // Model: one outstanding transaction; next grant goes to the first requester after the last one served.
  bit            mBusy = 1'b0;
  int            mId = 0;
  int            mLast = NR - 1;
  logic [7:0]    mTag = '0;
  logic [AW-1:0] mAddr = '0;
  logic          mDir = 1'b0;
  logic [3:0]    mBe = '0;
  logic [31:0]   mWdata = '0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCompared++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clock) begin
    int c;
    c = -1;
    if (!reset_n) begin
      mBusy = 1'b0; mId = 0; mLast = NR - 1;
      mTag = '0; mAddr = '0; mDir = 1'b0; mBe = '0; mWdata = '0;
    end else if (mBusy) begin
      if (mem32_dack_tag == mTag) begin
        mBusy = 1'b0;
        if (!(PRIO && mId == 0)) mLast = mId;
      end
    end else begin
      if (PRIO && req_request[0]) c = 0;
      else begin
        for (int off = 1; off <= NR; off++) begin
          int k;
          k = (mLast + off) % NR;
          if (c < 0 && req_request[k] && !(PRIO && k == 0)) c = k;
        end
      end
      if (c >= 0) begin
        mBusy  = 1'b1;
        mId    = c;
        mAddr  = req_address[c*AW +: AW];
        mDir   = req_direction[c];
        mBe    = req_byte_en[c*4 +: 4];
        mWdata = req_wdata[c*32 +: 32];
        mTag   = {1'b1, 2'(c), req_tag[c*5 +: 5]};
      end
    end
  end

  always @(negedge clock) begin
    logic [NR-1:0] expDack, expRack;
    expDack = '0;
    expRack = '0;
    if (checkEn) begin
      if (mBusy && reset_n && mem32_dack_tag == mTag) expDack[mId] = 1'b1;
      if (mem32_rack && mem32_rack_tag[7] && int'(mem32_rack_tag[6:5]) < NR)
        expRack[mem32_rack_tag[6:5]] = 1'b1;
      checkOutput("mem32_request", mem32_request, mBusy);
      checkOutput("mem32_tag", mem32_tag, mTag);
      checkOutput("mem32_address", mem32_address, mAddr);
      checkOutput("mem32_direction", mem32_direction, mDir);
      checkOutput("mem32_byte_en", mem32_byte_en, mBe);
      checkOutput("mem32_wdata", mem32_wdata, mWdata);
      checkOutput("req_dack", req_dack, expDack);
      checkOutput("req_rack", req_rack, expRack);
      checkOutput("req_rack_tag", req_rack_tag, mem32_rack_tag[4:0]);
      checkOutput("req_rdata", req_rdata, mem32_rdata);
      for (int j = 0; j < NR; j++) begin
        if (req_dack[j]) begin
          dackLog.push_back(j);
          dackCnt[j]++;
        end
      end
      if (req_rack != '0) rackCnt++;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input int c, input logic [AW-1:0] addr, input logic dir,
                               input logic [3:0] be, input logic [31:0] wd, input logic [4:0] tg);
    req_address[c*AW +: AW] = addr;
    req_direction[c]        = dir;
    req_byte_en[c*4 +: 4]   = be;
    req_wdata[c*32 +: 32]   = wd;
    req_tag[c*5 +: 5]       = tg;
    req_request[c]          = 1'b1;
  endtask

  task automatic clearReq(input int c);
    req_request[c] = 1'b0;
  endtask

  task automatic waitRequest(input string name);
    int n;
    n = 0;
    while (!mem32_request && n < 20) begin
      tick();
      n++;
    end
    checkOutput(name, mem32_request, 1'b1);
  endtask

  task automatic ackAfter(input int delay, input logic [7:0] tg);
    repeat (delay) tick();
    mem32_dack_tag = tg;
    tick();
    mem32_dack_tag = '0;
  endtask

  task automatic resetDut();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  task automatic checkOrder(input string name, input int exp0, input int exp1,
                            input int exp2, input int exp3, input int exp4, input int n);
    int expv[5];
    expv = '{exp0, exp1, exp2, exp3, exp4};
    checkOutput({name, "_count"}, dackLog.size(), n);
    for (int i = 0; i < n && i < dackLog.size(); i++)
      checkOutput($sformatf("%s_%0d", name, i), dackLog[i], expv[i]);
  endtask

  initial begin
    int d0, r0;
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int d0, r0;
    tick();
    checkEn = 1'b1;
    tick();
    checkOutput("reset_request", mem32_request, 1'b0);
    checkOutput("reset_tag", mem32_tag, 8'h00);
    checkOutput("reset_dack", req_dack, 4'b0000);
    reset_n = 1'b1;
    tick();

    // Single read from client 2.
    applyStimulus(2, 26'h0123456, 1'b0, 4'hF, 32'h0, 5'd5);
    waitRequest("single_wait");
    checkOutput("single_tag", mem32_tag, 8'hC5);
    checkOutput("single_addr", mem32_address, 26'h0123456);
    repeat (3) tick();
    mem32_dack_tag = 8'hC5;
    #1;
    checkOutput("single_dack", req_dack, 4'b0100);
    tick();
    mem32_dack_tag = '0;
    clearReq(2);
    checkOutput("single_req_drop", mem32_request, 1'b0);
    repeat (2) tick();
    mem32_rack = 1'b1; mem32_rack_tag = 8'hC5; mem32_rdata = 32'hDEADBEEF;
    #1;
    checkOutput("single_rack", req_rack, 4'b0100);
    checkOutput("single_rack_tag", req_rack_tag, 5'd5);
    checkOutput("single_rdata", req_rdata, 32'hDEADBEEF);
    tick();
    mem32_rack = 1'b0; mem32_rack_tag = '0; mem32_rdata = '0;

    // All four clients continuously requesting.
    resetDut();
    dackLog.delete();
    for (int k = 0; k < NR; k++) applyStimulus(k, AW'(k * 256), 1'b0, 4'hF, 32'h0, 5'(k));
    for (int g = 0; g < 5; g++) begin
      waitRequest("rr_wait");
      ackAfter(1, mem32_tag);
      if (g == 4) for (int k = 0; k < NR; k++) clearReq(k);
      checkOutput("rr_gap_low", mem32_request, 1'b0);
      if (g < 4) begin
        tick();
        checkOutput("rr_gap_high", mem32_request, 1'b1);
      end
    end
    if (PRIO) checkOrder("rr_order", 0, 0, 0, 0, 0, 5);
    else      checkOrder("rr_order", 0, 1, 2, 3, 0, 5);
    tick();

    // Foreign and out-of-range return tags, then a mismatching accept.
    mem32_rack = 1'b1; mem32_rack_tag = 8'h45; mem32_rdata = 32'h1;
    #1;
    checkOutput("foreign_rack", req_rack, 4'b0000);
    tick();
    mem32_rack_tag = 8'hE0;
    #1;
    checkOutput("id3_rack_n3", n3Rack, 3'b000);
    checkOutput("id3_rack_n4", req_rack, 4'b1000);
    tick();
    mem32_rack = 1'b0; mem32_rack_tag = '0; mem32_rdata = '0;
    applyStimulus(0, 26'h0000100, 1'b0, 4'hF, 32'h0, 5'd5);
    waitRequest("bad_wait");
    checkOutput("bad_pending_tag", mem32_tag, 8'h85);
    mem32_dack_tag = 8'h81;
    #1;
    checkOutput("bad_dack_none", req_dack, 4'b0000);
    tick();
    mem32_dack_tag = '0;
    checkOutput("bad_dack_pending", mem32_request, 1'b1);
    ackAfter(1, 8'h85);
    clearReq(0);
    tick();

    // Write from client 1.
    d0 = dackCnt[1];
    r0 = rackCnt;
    applyStimulus(1, 26'h0000040, 1'b1, 4'b0011, 32'h11223344, 5'd3);
    waitRequest("write_wait");
    checkOutput("write_dir", mem32_direction, 1'b1);
    checkOutput("write_wdata", mem32_wdata, 32'h11223344);
    checkOutput("write_be", mem32_byte_en, 4'b0011);
    checkOutput("write_tag", mem32_tag, 8'hA3);
    ackAfter(2, 8'hA3);
    clearReq(1);
    repeat (3) tick();
    checkOutput("write_dack_once", dackCnt[1] - d0, 1);
    checkOutput("write_no_rack", rackCnt - r0, 0);

    // Reset while client 3 is pending; pointer was at 2 before reset.
    d0 = dackCnt[3];
    applyStimulus(3, 26'h0000300, 1'b0, 4'hF, 32'h0, 5'd7);
    waitRequest("rst_wait");
    tick();
    reset_n = 1'b0;
    clearReq(3);
    tick();
    reset_n = 1'b1;
    checkOutput("rst_req_low", mem32_request, 1'b0);
    checkOutput("rst_no_dack", dackCnt[3] - d0, 0);
    applyStimulus(0, 26'h0000010, 1'b0, 4'hF, 32'h0, 5'd1);
    applyStimulus(2, 26'h0000020, 1'b0, 4'hF, 32'h0, 5'd2);
    waitRequest("rst_wait0");
    checkOutput("rst_rrptr0", mem32_tag, 8'h81);
    ackAfter(1, mem32_tag);
    clearReq(0);
    waitRequest("rst_wait2");
    checkOutput("rst_next2", mem32_tag, 8'hC2);
    ackAfter(1, mem32_tag);
    clearReq(2);
    tick();

    // Clients 0 and 3 continuously requesting.
    resetDut();
    dackLog.delete();
    applyStimulus(0, 26'h0000001, 1'b0, 4'hF, 32'h0, 5'd0);
    applyStimulus(3, 26'h0000003, 1'b0, 4'hF, 32'h0, 5'd3);
    for (int g = 0; g < 4; g++) begin
      waitRequest("prio_wait");
      ackAfter(1, mem32_tag);
      if (g == 3) begin
        clearReq(0);
        clearReq(3);
      end
    end
    if (PRIO) checkOrder("prio_order", 0, 0, 0, 0, 0, 4);
    else      checkOrder("prio_order", 0, 3, 0, 3, 0, 4);

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFail);
    $finish;
  end

endmodule

// File: doc/mem32_arbiter.md
Name: mem32_arbiter

Overview:
- Shares the single 32-bit memory request port (mem32_*) of the NIOS/DDR subsystem between NUM_REQ client requesters.
- Arbitration is round-robin. Each issued request is tagged with the client ID so that read data returning on mem32_rack/mem32_rack_tag is steered back to the owning client.
- Sits between the client masters (CPU cache, DMA, video fetch, drive emulation) and the memory subsystem, in the sys clock domain.

Parameters:
- NUM_REQ, 4: number of clients; legal range 2..4 (2-bit ID field).
- ADDR_W, 26: address width, matches mem32_address.

Ports:
- clock  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- req_request  in  NUM_REQ  per-client request, held until its req_dack
- req_address  in  NUM_REQ*ADDR_W  client i at bits [i*ADDR_W +: ADDR_W]
- req_direction  in  NUM_REQ  1 = write, 0 = read
- req_byte_en  in  NUM_REQ*4  byte enables
- req_wdata  in  NUM_REQ*32  write data
- req_tag  in  NUM_REQ*5  client-local tag
- req_dack  out  NUM_REQ  one-hot accept pulse
- req_rack  out  NUM_REQ  one-hot read-return strobe
- req_rack_tag  out  5  local tag of the returning read
- req_rdata  out  32  read data, broadcast to all clients
- mem32_request  out  1  request to memory
- mem32_address  out  ADDR_W  latched address
- mem32_direction  out  1  latched direction
- mem32_byte_en  out  4  latched byte enables
- mem32_wdata  out  32  latched write data
- mem32_tag  out  8  {1'b1, id[1:0], local_tag[4:0]}
- mem32_dack_tag  in  8  accept tag from memory; 0 = no accept
- mem32_rdata  in  32  read data
- mem32_rack  in  1  read-return strobe
- mem32_rack_tag  in  8  tag of the returning read

Behaviour:
- One clock domain. reset_n is sampled on the rising edge of clock (synchronous, active low).
- Reset values:
  - mem32_request = 0; mem32_address, mem32_direction, mem32_byte_en, mem32_wdata, mem32_tag = 0.
  - state = IDLE, rr_ptr = 0, grant = 0.
  - req_dack = 0. Return outputs are combinational (see below).
- FSM, IDLE:
  - Selects the first active req_request[i], searching from rr_ptr upward with wrap at NUM_REQ.
  - On a hit, registers the client's address/direction/byte_en/wdata and mem32_tag = {1, i, req_tag_i}, sets mem32_request = 1 and grant = i, then moves to ISSUE.
  - Arbitration to mem32_request takes 1 cycle.
  - No active request: stays in IDLE, outputs hold.
- FSM, ISSUE:
  - mem32_request is held and all latched fields stay stable.
  - When mem32_dack_tag == mem32_tag:
    - req_dack[grant] = 1 combinationally in that same cycle.
    - Next edge: mem32_request = 0, rr_ptr = grant+1 (wrapping to 0 past NUM_REQ-1), state = IDLE.
  - A dack_tag that does not match (including 0) is ignored.
- Client rule: a client drops req_request, or presents its next request, on the cycle after req_dack.
  - Because IDLE follows ISSUE, back-to-back grants are spaced by at least 1 idle cycle on mem32_request.
- Read return (combinational, stateless):
  - req_rdata = mem32_rdata.
  - req_rack_tag = mem32_rack_tag[4:0].
  - req_rack[j] = mem32_rack & mem32_rack_tag[7] & (mem32_rack_tag[6:5] == j).
  - Returns with tag bit 7 = 0, or with an ID >= NUM_REQ, produce no strobe.
- Simultaneous events:
  - A read return may coincide with any FSM state and is unaffected.
  - A new request arriving in ISSUE waits.
  - Clients whose request is still high after being served are deprioritised by the rr_ptr update.
- Fairness: every continuously active client is granted within NUM_REQ grants.
- Reset mid-ISSUE: the request is dropped next edge and no req_dack is issued. Returns arriving after reset are still routed, since routing is stateless.
- Writes produce no rack. req_dack is the only completion a write client receives.

Optional Feature:
- Macro: MEM32_ARB_PRIO0_EN.
- Defined: client 0 has fixed top priority. In IDLE, if req_request[0] = 1 it is granted regardless of rr_ptr. Clients 1..NUM_REQ-1 remain round-robin among themselves, and rr_ptr is not advanced by client-0 grants.
- Undefined: pure round-robin over all clients as described above.

Test Plan:
- Single read:
  - Stimulus: client 2 requests addr 0x0123456, tag 5; memory returns dack_tag 0xC5 after 3 cycles; later rack with rack_tag 0xC5, rdata 0xDEADBEEF.
  - Required: mem32_tag = 0xC5; req_dack = 0100 in the dack cycle; req_rack = 0100, req_rack_tag = 5, req_rdata = 0xDEADBEEF.
- Round-robin:
  - Stimulus: all 4 clients request continuously; memory acks every request 1 cycle after issue.
  - Required: grant order 0,1,2,3,0; mem32_request drops for exactly 1 cycle between grants.
- Foreign and bad tags:
  - Stimulus: rack with rack_tag 0x45; rack with rack_tag 0xE0 when NUM_REQ = 3; dack_tag 0x81 while 0x85 is pending.
  - Required: req_rack stays 0 for both returns; the pending request stays asserted.
- Write:
  - Stimulus: client 1 writes byte_en 0011, wdata 0x11223344.
  - Required: mem32_direction = 1 and mem32_wdata/byte_en match while request is held; req_dack[1] pulses once; no req_rack.
- Reset mid-ISSUE:
  - Stimulus: assert reset_n = 0 for 1 cycle while a request is pending.
  - Required: mem32_request = 0 and state IDLE next cycle; no req_dack; rr_ptr = 0.
- Priority (MEM32_ARB_PRIO0_EN defined):
  - Stimulus: clients 0 and 3 request continuously.
  - Required: client 0 wins every grant; with the macro undefined, grants alternate 0,3,0,3.
